// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the countdown-timer digit counters
package timer_pkg;
    localparam int MOD6 = 6;
    localparam int DIGIT_W = 3;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX6 = 3'd5;
endpackage

// File: rtl/contador_mod6.sv
// contador_mod6: loadable modulo-6 down counter with terminal-count flag for the tens-of-seconds digit
module contador_mod6
    import timer_pkg::*;
#(
    parameter int MOD = MOD6,
    parameter int WIDTH = DIGIT_W
) (
    input  logic [WIDTH-1:0] data,
    input  logic             clk,
    input  logic             load,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    input  logic             stop
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= '0;
        else if (load)
            count <= (data > MAX) ? MAX : data;
        else if (stop)
            count <= (count == '0 || count > MAX) ? MAX : count - 1'b1;
    assign tc = (count == '0);
endmodule

// File: tb/tb_contador_mod6.sv
// tb_contador_mod6: directed self-checking bench for contador_mod6
module tb_contador_mod6;
    logic [2:0] data;
    logic       clk;
    logic       load;
    logic       reset;
    logic [2:0] count;
    logic       tc;
    logic       stop;
    logic       run;
    int         errors;
    int         checks;
    logic [2:0] seq [13];
    contador_mod6 dut (
        .data (data),
        .clk  (clk),
        .load (load),
        .reset(reset),
        .count(count),
        .tc   (tc),
        .stop (stop)
    );
    always #5 clk = run ? ~clk : clk;
    task automatic chk(input string tag, input logic [2:0] exp_c, input logic exp_t);
        checks++;
        assert (count === exp_c)
        else begin
            errors++;
            $error("FAIL %s count=%0d expected %0d", tag, count, exp_c);
        end
        checks++;
        assert (tc === exp_t)
        else begin
            errors++;
            $error("FAIL %s tc=%0b expected %0b", tag, tc, exp_t);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        errors = 0;
        checks = 0;
        clk = 0;
        run = 0;
        reset = 1;
        data = 0;
        load = 0;
        stop = 0;
        seq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
        #5 reset = 0;
        #1 chk("reset_idle", 3'd0, 1'b1);
        #4 reset = 1;
        stop = 1;
        run = 1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk($sformatf("wrap_%0d", i), seq[i], seq[i] == 3'd0);
        end
        load = 1;
        data = 3;
        step();
        chk("load3", 3'd3, 1'b0);
        load = 0;
        step();
        chk("dec_2", 3'd2, 1'b0);
        step();
        chk("dec_1", 3'd1, 1'b0);
        step();
        chk("dec_0", 3'd0, 1'b1);
        step();
        chk("wrap_5", 3'd5, 1'b0);
        step();
        chk("dec_4", 3'd4, 1'b0);
        stop = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold_%0d", i), 3'd4, 1'b0);
        end
        load = 1;
        data = 1;
        step();
        chk("load1_nostop", 3'd1, 1'b0);
        data = 7;
        step();
        chk("load7_sat", 3'd5, 1'b0);
        load = 0;
        stop = 1;
        step();
        chk("sat_dec_4", 3'd4, 1'b0);
        step();
        chk("sat_dec_3", 3'd3, 1'b0);
        step();
        chk("sat_dec_2", 3'd2, 1'b0);
        #2 reset = 0;
        #1 chk("reset_mid", 3'd0, 1'b1);
        reset = 1;
        step();
        chk("after_reset", 3'd5, 1'b0);
        load = 1;
        data = 0;
        step();
        chk("load_wins", 3'd0, 1'b1);
        load = 0;
        stop = 0;
        data = 'x;
        step();
        chk("x_data_hold", 3'd0, 1'b1);
        data = 6;
        load = 1;
        step();
        chk("load6_sat", 3'd5, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
